// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
//   INST_WIDTH / INST_ADDR_WIDTH : instruction word and fetch address widths
//   IFQ_DEPTH                    : default queue depth / outstanding-request limit
//   ifq_state_e                  : FETCH (responses enqueue) / DRAIN (stale responses dropped)
//   ifq_entry_t                  : one queue entry, {instruction, address}
package inst_fetch_queue_pkg;

  localparam int INST_WIDTH      = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int IFQ_DEPTH       = 4;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifq_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0]      inst;
    logic [INST_ADDR_WIDTH-1:0] addr;
  } ifq_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [INST_ADDR_WIDTH-1:0] word_align(
    input logic [INST_ADDR_WIDTH-1:0] a
  );
    return a & ~INST_ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Storage ring for the instruction fetch queue. Holds only data and
// read/write pointers; occupancy is tracked by the owner, which never pushes
// into a full ring nor pops an empty one.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write one entry at the tail
//   pop             : retire the head entry
//   clear           : drop all entries (pointers back to zero), wins over push/pop
//   head_data       : entry at the head (meaningful only when occupancy != 0)
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to instruction
// memory, buffers in-order responses with their addresses, and hands them to
// IF/ID. A redirect flushes the queue and refetches from the new address;
// responses still in flight for the old stream are counted and dropped.
//   clk, rst                       : clock, asynchronous active-low reset
//   mem_req_o/mem_addr_o/mem_gnt_i : fetch request handshake
//   mem_rvalid_i/mem_rdata_i       : in-order fetch responses
//   redirect_i/redirect_addr_i     : control-flow change from the core
//   inst_valid_o/inst_o/inst_addr_o: queue head toward IF/ID
//   inst_ready_i                   : core consumes the head this cycle
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                         DEPTH    = IFQ_DEPTH,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req_o,
  output logic [INST_ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [INST_WIDTH-1:0]      mem_rdata_i,
  input  logic                       redirect_i,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                       inst_valid_o,
  output logic [INST_WIDTH-1:0]      inst_o,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
  input  logic                       inst_ready_i
);

  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

  ifq_state_e                 state_q, state_d;
  logic [CW-1:0]              count_q, count_d;
  logic [CW-1:0]              outstanding_q, outstanding_d;
  logic [CW-1:0]              discard_q, discard_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INST_ADDR_WIDTH-1:0] rsp_ptr_q, rsp_ptr_d;

  logic       grant, rsp, push, pop;
  logic [CW:0] inflight;
  ifq_entry_t push_entry, head_entry;

  // Queue slots are reserved at request time: occupied + in flight never
  // exceeds DEPTH, so every accepted response is guaranteed a slot.
  assign inflight  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign mem_req_o = rst & ~redirect_i & (inflight < DEPTH_C);
  assign mem_addr_o = pc_q;
  assign grant     = mem_req_o & mem_gnt_i;

  // A response with nothing outstanding cannot be ours; ignore it.
  assign rsp  = mem_rvalid_i & (outstanding_q != '0);
  // Responses in the redirect cycle or while draining belong to the old stream.
  assign push = rsp & (state_q == FETCH) & ~redirect_i;
  assign pop  = inst_valid_o & inst_ready_i & ~redirect_i;

  assign push_entry = '{inst: mem_rdata_i, addr: rsp_ptr_q};

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !rsp)      outstanding_d = outstanding_q + 1'b1;
    else if (!grant && rsp) outstanding_d = outstanding_q - 1'b1;

    count_d = count_q;
    if (redirect_i)         count_d = '0;
    else if (push && !pop)  count_d = count_q + 1'b1;
    else if (!push && pop)  count_d = count_q - 1'b1;
  end

  // Next-state: FSM, discard counter and the two address pointers.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_d      = pc_q;
    rsp_ptr_d = rsp_ptr_q;
    if (grant) pc_d      = pc_q + 32'd4;
    if (push)  rsp_ptr_d = rsp_ptr_q + 32'd4;
    if (redirect_i) begin
      // Everything still in flight (minus this cycle's response) is stale,
      // including requests already issued to a previous redirect target.
      pc_d      = word_align(redirect_addr_i);
      rsp_ptr_d = word_align(redirect_addr_i);
      discard_d = outstanding_q - CW'(rsp);
      state_d   = (discard_d != '0) ? DRAIN : FETCH;
    end else if (state_q == DRAIN && rsp) begin
      discard_d = discard_q - 1'b1;
      if (discard_q == CW'(1)) state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      pc_q          <= RESET_PC;
      rsp_ptr_q     <= RESET_PC;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pc_q          <= pc_d;
      rsp_ptr_q     <= rsp_ptr_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifq_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect_i),
    .head_data (head_entry)
  );

  // Head is forced to zero when empty so stale ring contents never show.
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? head_entry.inst : '0;
  assign inst_addr_o  = inst_valid_o ? head_entry.addr : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue. A memory model grants requests
// while its budget lasts and answers in order one cycle later; the request
// checker and the IF/ID monitor pop expected values queued by the stimulus.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i  = '0;
  logic        redirect_i   = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_ready_i = 1'b0;

  int checks = 0, failures = 0;
  int cyc = 0, grant_cnt = 0, budget = 0;
  bit resp_en = 1'b1;
  int pop_cnt = 0, first_pop = 0, last_pop = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_iaddr_q[$];
  logic [31:0] pend[$];

  logic        m_g;
  logic [31:0] m_ga, m_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_gnt_i = (budget > 0);

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_ready_i(inst_ready_i)
  );

  // Memory contents: each word is its address xor a fixed pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic expect_inst(input logic [31:0] a);
    exp_inst_q.push_back(mem_word(a));
    exp_iaddr_q.push_back(a);
  endtask

  // Stimulus changes land 2 time units after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int max);
    int k = 0;
    while ((exp_inst_q.size() != 0 || exp_addr_q.size() != 0) && k < max) begin
      step(1);
      k++;
    end
    check({"drain_", name}, exp_inst_q.size() + exp_addr_q.size(), 0);
    step(2);
  endtask

  // Memory model + request checker: sample at the falling edge (inputs are
  // stable until the next rising edge), respond just after the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      m_g  = mem_req_o & mem_gnt_i;
      m_ga = mem_addr_o;
      @(posedge clk);
      #1;
      if (!rst) begin
        pend.delete();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
      end else begin
        if (m_g) begin
          grant_cnt++;
          budget--;
          if (exp_addr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL fetch_addr actual=%h expected=none", m_ga);
          end else check("fetch_addr", m_ga, exp_addr_q.pop_front());
          pend.push_back(m_ga);
        end
        if (resp_en && pend.size() != 0) begin
          m_a = pend.pop_front();
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mem_word(m_a);
        end else begin
          mem_rvalid_i = 1'b0;
          mem_rdata_i  = '0;
        end
      end
    end
  end

  // IF/ID monitor: every consumed head must be the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && inst_valid_o && inst_ready_i && !redirect_i) begin
        if (pop_cnt == 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
        if (exp_inst_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL inst_out actual=%h@%h expected=none", inst_o, inst_addr_o);
        end else begin
          check("inst_out", inst_o, exp_inst_q.pop_front());
          check("inst_addr_out", inst_addr_o, exp_iaddr_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int g0, rel;
    step(2);
    // Reset state.
    check("rst_req", mem_req_o, 0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_inst_addr", inst_addr_o, 0);
    check("rst_pc", mem_addr_o, 32'h0);

    // Streaming: 8 fetches from 0, consumed back to back.
    for (int i = 0; i < 8; i++) begin
      expect_fetch(32'(i * 4));
      expect_inst(32'(i * 4));
    end
    budget = 8; inst_ready_i = 1'b1; pop_cnt = 0;
    rst = 1'b1; rel = cyc;
    wait_drain("stream", 40);
    check("stream_pops", pop_cnt, 8);
    check("stream_startup", first_pop - rel, 2);
    check("stream_back_to_back", last_pop - first_pop, 7);

    // Stall: consumer not ready, exactly DEPTH requests go out.
    for (int i = 0; i < 4; i++) begin
      expect_fetch(32'(32 + i * 4));
      expect_inst(32'(32 + i * 4));
    end
    inst_ready_i = 1'b0; budget = 100; g0 = grant_cnt;
    step(10);
    check("stall_grants", grant_cnt - g0, 4);
    check("stall_req_low", mem_req_o, 0);
    check("stall_valid", inst_valid_o, 1);
    check("stall_head_addr", inst_addr_o, 32'h20);
    budget = 0; inst_ready_i = 1'b1;
    wait_drain("stall", 40);

    // Redirect with 3 responses outstanding.
    expect_fetch(32'h30); expect_fetch(32'h34); expect_fetch(32'h38);
    resp_en = 1'b0; budget = 3; g0 = grant_cnt;
    step(5);
    check("hold_grants", grant_cnt - g0, 3);
    check("hold_valid", inst_valid_o, 0);
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103; budget = 2;
    expect_fetch(32'h100); expect_fetch(32'h104);
    expect_inst(32'h100);  expect_inst(32'h104);
    #1;
    check("redirect_req_low", mem_req_o, 0);
    step(1);
    redirect_i = 1'b0;
    check("redirect_next_pc", mem_addr_o, 32'h100);
    resp_en = 1'b1;
    wait_drain("redirect", 40);

    // Redirect coincident with a response, then redirect again while draining.
    expect_fetch(32'h108); expect_fetch(32'h10C); expect_fetch(32'h110);
    resp_en = 1'b0; budget = 3;
    step(5);
    resp_en = 1'b1;
    step(1);
    redirect_i = 1'b1; redirect_addr_i = 32'h0000_0200;
    step(1);
    redirect_addr_i = 32'h0000_0300; budget = 2;
    expect_fetch(32'h300); expect_fetch(32'h304);
    expect_inst(32'h300);  expect_inst(32'h304);
    step(1);
    redirect_i = 1'b0;
    check("second_redirect_pc", mem_addr_o, 32'h300);
    wait_drain("double_redirect", 40);

    // Address wrap at the top of the space.
    redirect_i = 1'b1; redirect_addr_i = 32'hFFFF_FFFC;
    step(1);
    redirect_i = 1'b0;
    check("wrap_pc", mem_addr_o, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC); expect_fetch(32'h0);
    expect_inst(32'hFFFF_FFFC);  expect_inst(32'h0);
    budget = 2;
    wait_drain("wrap", 40);

    // Reset with two queued words and two requests in flight.
    inst_ready_i = 1'b0;
    expect_fetch(32'h4); expect_fetch(32'h8);
    budget = 2;
    step(5);
    resp_en = 1'b0;
    expect_fetch(32'hC); expect_fetch(32'h10);
    budget = 2;
    step(4);
    check("pre_reset_valid", inst_valid_o, 1);
    check("pre_reset_req", mem_req_o, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_req", mem_req_o, 0);
    check("mid_rst_valid", inst_valid_o, 0);
    check("mid_rst_inst", inst_o, 0);
    check("mid_rst_inst_addr", inst_addr_o, 0);
    check("mid_rst_pc", mem_addr_o, 32'h0);
    step(2);
    resp_en = 1'b1;
    expect_fetch(32'h0); expect_inst(32'h0);
    budget = 1; inst_ready_i = 1'b1;
    rst = 1'b1;
    wait_drain("post_reset", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
